// File: rtl/motion_fetch_scheduler.sv
// Frame-fetch controller: shares one memory read port between the base and current-frame FIFOs, then counts drained output pixels.
// Optional build macro MOTION_SCHED_BASE_FIRST_EN fetches the whole base frame before any current-frame pixel.
module motion_fetch_scheduler #(
  parameter int WIDTH      = 768,
  parameter int HEIGHT     = 576,
  parameter int ADDR_WIDTH = 20,
  parameter int BASE_ADDR  = 0,
  parameter int IMG_ADDR   = WIDTH * HEIGHT
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [23:0]           mem_rd_data,
  input  logic                  base_full,
  output logic                  base_wr_en,
  output logic [23:0]           base_din,
  input  logic                  img_in_full,
  input  logic                  original_full,
  output logic                  img_in_wr_en,
  output logic                  original_wr_en,
  output logic [23:0]           img_in_din,
  output logic [23:0]           original_din,
  input  logic                  img_out_rd_en,
  input  logic                  img_out_empty,
  output logic                  busy,
  output logic                  done
);

  localparam int N     = WIDTH * HEIGHT;
  localparam int CNT_W = $clog2(N + 1);
  localparam logic [CNT_W-1:0]      N_C    = CNT_W'(N);
  localparam logic [ADDR_WIDTH-1:0] BASE_A = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] IMG_A  = ADDR_WIDTH'(IMG_ADDR);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] base_cnt, img_cnt, out_cnt, out_cnt_nxt;
  logic             ptr;
  logic             b_vld_p1, i_vld_p1;
  logic             b_elig, i_elig, grant_b, grant_i, out_hs;

  always_comb begin
    b_elig = (state == FETCH) && (base_cnt < N_C) && !base_full && !b_vld_p1;
    i_elig = (state == FETCH) && (img_cnt < N_C) && !img_in_full && !original_full && !i_vld_p1;
`ifdef MOTION_SCHED_BASE_FIRST_EN
    i_elig = i_elig && (base_cnt == N_C);
`else
    i_elig = i_elig;
`endif
    // ptr = 0 points at the base stream; the pointed-to stream wins a tie
    grant_b = b_elig && (!ptr || !i_elig);
    grant_i = i_elig && (ptr || !b_elig);
  end

  always_comb begin
    mem_rd_en = grant_b || grant_i;
    mem_addr  = '0;
    if (grant_b)
      mem_addr = BASE_A + ADDR_WIDTH'(base_cnt);
    else if (grant_i)
      mem_addr = IMG_A + ADDR_WIDTH'(img_cnt);
  end

  always_comb begin
    out_hs      = img_out_rd_en && !img_out_empty && ((state == FETCH) || (state == DRAIN));
    out_cnt_nxt = (out_hs && (out_cnt != N_C)) ? out_cnt + 1'b1 : out_cnt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = FETCH;
      // once both counts are full nothing new can issue; the last write lands this cycle
      FETCH:   if ((base_cnt == N_C) && (img_cnt == N_C)) state_nxt = DRAIN;
      DRAIN:   if (out_cnt_nxt == N_C) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0 -> p1: issue bookkeeping, the target is registered with the read
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      base_cnt <= '0;
      img_cnt  <= '0;
      out_cnt  <= '0;
      ptr      <= 1'b0;
      b_vld_p1 <= 1'b0;
      i_vld_p1 <= 1'b0;
    end else begin
      state    <= state_nxt;
      b_vld_p1 <= grant_b;
      i_vld_p1 <= grant_i;
      if (grant_b || grant_i)
        ptr <= grant_b;
      if ((state == IDLE) && start) begin
        base_cnt <= '0;
        img_cnt  <= '0;
        out_cnt  <= '0;
      end else begin
        if (grant_b) base_cnt <= base_cnt + 1'b1;
        if (grant_i) img_cnt  <= img_cnt + 1'b1;
        out_cnt <= out_cnt_nxt;
      end
    end
  end

  // Stage p1: returning read data is written into the FIFO that issued it
  always_comb begin
    base_wr_en     = b_vld_p1;
    base_din       = b_vld_p1 ? mem_rd_data : '0;
    img_in_wr_en   = i_vld_p1;
    original_wr_en = i_vld_p1;
    img_in_din     = i_vld_p1 ? mem_rd_data : '0;
    original_din   = i_vld_p1 ? mem_rd_data : '0;
    busy           = (state != IDLE);
    done           = (state == DONE);
  end

endmodule

// File: doc/motion_fetch_scheduler.md
# motion_fetch_scheduler

Frame-fetch controller sitting in front of `motion_detect_top`. It shares one single-ported frame memory read port between the background (base) stream and the current-frame stream. It fills the base FIFO and the lockstep img_in/original FIFOs with flow control on their full flags. It then counts pixels drained from the output FIFO and signals frame completion.

## Interface
Parameters:
- `WIDTH`, 768, pixels per line
- `HEIGHT`, 576, lines per frame; N = WIDTH*HEIGHT pixels
- `ADDR_WIDTH`, 20, memory word address width; must satisfy 2^ADDR_WIDTH ≥ IMG_ADDR + N
- `BASE_ADDR`, 0, word address of base-frame pixel 0
- `IMG_ADDR`, WIDTH*HEIGHT, word address of current-frame pixel 0

Ports:
- `clock` in 1: clock
- `reset` in 1: reset, asynchronous, active-low
- `start` in 1: single-cycle frame start request
- `mem_rd_en` out 1: memory read strobe
- `mem_addr` out ADDR_WIDTH: read address, valid with `mem_rd_en`
- `mem_rd_data` in 24: read data, valid exactly 1 cycle after `mem_rd_en`
- `base_full` in 1: base FIFO full
- `base_wr_en` out 1: base FIFO write
- `base_din` out 24: base FIFO data
- `img_in_full`, `original_full` in 1 each: current-frame FIFO full flags
- `img_in_wr_en`, `original_wr_en` out 1 each: always driven identically
- `img_in_din`, `original_din` out 24 each: always identical
- `img_out_rd_en`, `img_out_empty` in 1 each: monitored consumer handshake on the output FIFO
- `busy` out 1: state ≠ IDLE
- `done` out 1: one-cycle frame-complete pulse

## Operation
- States:
  - IDLE: `start` → FETCH; clears base_cnt, img_cnt and out_cnt.
  - FETCH: moves to DRAIN when base_cnt = N, img_cnt = N and no read is in flight.
  - DRAIN: moves to DONE when out_cnt = N.
  - DONE: asserts `done` for one cycle, then returns to IDLE unconditionally.
- `start` is ignored outside IDLE.
- Target B (base) is eligible when base_cnt < N, `base_full` = 0, and no B read was issued last cycle.
- Target I (current frame) is eligible when img_cnt < N, `img_in_full` = 0, `original_full` = 0, and no I read was issued last cycle.
- Round-robin pointer: reset value is B. The pointed-to target is granted if eligible; otherwise the other target is granted if eligible. After any grant the pointer moves to the non-granted target.
- Grant to B: `mem_rd_en` = 1, `mem_addr` = BASE_ADDR + base_cnt, base_cnt++.
- Grant to I: `mem_rd_en` = 1, `mem_addr` = IMG_ADDR + img_cnt, img_cnt++.
- The target is registered with the read. Next cycle, `mem_rd_data` drives the target's din and wr_en is asserted for 1 cycle.
- There is at most one in-flight read per target. Because `full` is sampled at issue, overflow is impossible.
- out_cnt increments on `img_out_rd_en` & !`img_out_empty` in FETCH or DRAIN, and saturates at N.
- Counters are ceil(log2(N+1)) bits. Addresses are computed modulo 2^ADDR_WIDTH; parameter legality is the integrator's responsibility.

## Timing
- All outputs reset to 0; state resets to IDLE and the pointer to B.
- Assertion of `reset` at any time, including mid-FETCH, aborts immediately. An in-flight write is dropped.
- Cycle after `start`: first read may issue.
- Read→FIFO write latency: exactly 1 cycle.
- Peak rate: 1 read/cycle while alternating B/I; a single target gets at most 1 read per 2 cycles.
- Minimum FETCH length is 2N cycles, plus 1 cycle for the final write.
- `done` asserts in the cycle after the clock edge on which out_cnt reaches N. `busy` drops in the cycle after `done`.
- Output handshakes arriving in IDLE or DONE are not counted.

## Configuration
- Macro `MOTION_SCHED_BASE_FIRST_EN`.
- Defined: strict priority. I is never eligible while base_cnt < N, so the whole base frame is fetched first at 1 read per 2 cycles. Fetch time is ≥ 4N cycles. For integrations whose pipeline must hold the background before streaming.
- Undefined: round-robin as described above.

## Test plan
Use WIDTH=4, HEIGHT=2 (N=8) and a memory model returning data = address.
- Start with no FIFO ever full: `mem_addr` sequence is 0,8,1,9,…,7,15 on 16 consecutive cycles. Base FIFO receives 0..7 and img/original receive 8..15 in order. After 8 output reads, `done` pulses once and `busy` then falls.
- Hold `base_full`=1 for 6 cycles after start: only I reads issue, on alternate cycles (8,9,10), with no `base_wr_en`. When `base_full` drops, alternation resumes with address 0.
- Pulse `start` again during FETCH: counters and address sequence are unaffected, and exactly one `done` is produced.
- Assert reset in the cycle after a read to address 3: all outputs are 0, no write occurs, state is IDLE. A new `start` restarts at address 0.
- Define `MOTION_SCHED_BASE_FIRST_EN`: addresses 0..7 issue on every other cycle, then 8..15 on every other cycle. `done` follows the 8th output read.
- Assert `img_out_rd_en` with `img_out_empty`=1: out_cnt does not advance and `done` is withheld until 8 valid reads.
